// File: rtl/mem_uart_tx_pkg.sv
// ---------------------------------------------------------------------------
// mem_uart_tx_pkg
// Shared definitions for the memory-mapped UART transmitter: register
// offsets inside the 4-word window, STATUS bit positions, TX state encoding
// and the serial frame length (start + 8 data + stop).
// ---------------------------------------------------------------------------
package mem_uart_tx_pkg;

  localparam logic [1:0] OFF_DATA   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_DIV    = 2'd2;
  localparam logic [1:0] OFF_RSVD   = 2'd3;

  localparam int ST_EMPTY  = 0;
  localparam int ST_FULL   = 1;
  localparam int ST_BUSY   = 2;
  localparam int ST_OVF    = 3;
  localparam int ST_IRQ_EN = 8;

  localparam int FRAME_BITS = 10;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/mem_uart_tx_responder_if.sv
// ---------------------------------------------------------------------------
// mem_uart_tx_responder_if
// CPU memory bus: word address, active-low read/write strobes and the shared
// 16-bit data bus yBus. Each side owns a data/enable pair and the bus value
// is resolved here, so the slave only drives yBus during a selected read.
//   aBus        : word address (master -> slave)
//   memNotRead  : active-low read strobe
//   memNotWrite : active-low write strobe
//   m_data/m_oe : master write data and its drive enable
//   s_data/s_oe : slave read data and its drive enable
//   yBus        : resolved data bus, high-Z when nobody drives
// ---------------------------------------------------------------------------
interface mem_uart_tx_responder_if;
  logic [15:0] aBus;
  logic        memNotRead;
  logic        memNotWrite;
  logic [15:0] m_data;
  logic        m_oe;
  logic [15:0] s_data;
  logic        s_oe;
  wire  [15:0] yBus;

  // Bus resolution: slave read data, else master write data, else floating
  assign yBus = s_oe ? s_data : (m_oe ? m_data : 16'hzzzz);

  modport master (output aBus, memNotRead, memNotWrite, m_data, m_oe,
                  input  yBus, s_oe);
  modport slave  (input  aBus, memNotRead, memNotWrite, yBus,
                  output s_data, s_oe);
endinterface

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with synchronous active-high reset. A push while full
// is dropped even if a pop happens in the same cycle; a pop while empty is
// ignored. DEPTH must be a power of two so pointers wrap naturally.
//   clk, rst        : clock, synchronous reset
//   i_push, i_data  : write request and data
//   i_pop           : read request (o_data is the current head)
//   o_full, o_empty : occupancy flags
//   o_count         : number of stored entries, 0..DEPTH
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == (AW + 1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  // Storage array, written only on an accepted push
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers and occupancy count
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mem_uart_tx_responder.sv
// ---------------------------------------------------------------------------
// mem_uart_tx_responder
// Memory-mapped UART transmitter on the CPU bus. Window BASE..BASE+3:
//   +0 DATA   (W)  push yBus[7:0] into the TX FIFO
//   +1 STATUS (RW) {irqEnable, count[3:0], overflow, busy, full, empty};
//                  writing bit 3 = 1 clears overflow
//   +2 DIV    (RW) bit period = DIV+1 clocks
//   +3        reads 0, writes ignored
// Reads are combinational; writes commit once per low pulse of memNotWrite.
// Ports:
//   clock, reset : clock and synchronous active-high reset
//   bus          : CPU memory bus (slave side)
//   txd          : 8N1 serial output, idle high
//   irq          : only with MEM_UART_TX_IRQ_EN; irqEnable & empty & !busy,
//                  registered
// ---------------------------------------------------------------------------
module mem_uart_tx_responder
  import mem_uart_tx_pkg::*;
#(
  parameter logic [15:0] BASE        = 16'hFF00,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
  input  logic                    clock,
  input  logic                    reset,
  mem_uart_tx_responder_if.slave  bus,
  output logic                    txd
`ifdef MEM_UART_TX_IRQ_EN
  ,
  output logic                    irq
`endif
);

  localparam int CW = ((FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1) + 1;

  logic            w_sel, w_rd, w_wr, w_push, w_pop, w_busy, w_irq_en;
  logic            w_full, w_empty;
  logic [1:0]      w_off;
  logic [CW-1:0]   w_count;
  logic [7:0]      w_fifo_data;
  logic [15:0]     w_status, w_rdata;
  logic            r_prev_nwr, r_overflow;
  logic [15:0]     r_div;
  tx_state_e       r_state, w_state_n;
  logic [15:0]     r_cnt, w_cnt_n;
  logic [2:0]      r_bit, w_bit_n;
  logic [7:0]      r_shift, w_shift_n;
  logic            r_txd, w_txd_n;

  assign w_sel  = (bus.aBus[15:2] == BASE[15:2]);
  assign w_off  = bus.aBus[1:0];
  // A read with the write strobe also low is treated as a write only
  assign w_rd   = w_sel & ~bus.memNotRead & bus.memNotWrite;
  // Falling edge of memNotWrite: one commit per pulse however long it is
  assign w_wr   = w_sel & ~bus.memNotWrite & r_prev_nwr;
  assign w_push = w_wr & (w_off == OFF_DATA);
  assign w_busy = (r_state != TX_IDLE);
  assign txd    = r_txd;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clock),
    .rst     (reset),
    .i_push  (w_push),
    .i_data  (bus.yBus[7:0]),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

`ifdef MEM_UART_TX_IRQ_EN
  logic r_irq_en, r_irq;
  assign w_irq_en = r_irq_en;
  assign irq      = r_irq;

  // Interrupt enable and the one-clock-late idle interrupt
  always_ff @(posedge clock) begin
    if (reset) begin
      r_irq_en <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (w_wr && (w_off == OFF_STATUS)) r_irq_en <= bus.yBus[ST_IRQ_EN];
      r_irq <= r_irq_en & w_empty & ~w_busy;
    end
  end
`else
  assign w_irq_en = 1'b0;
`endif

  always_comb begin
    w_status = {7'b0, w_irq_en, 4'(w_count), r_overflow, w_busy, w_full, w_empty};
  end

  // Read data mux; offsets without readable content return zero
  always_comb begin
    w_rdata = 16'h0000;
    case (w_off)
      OFF_STATUS: w_rdata = w_status;
      OFF_DIV:    w_rdata = r_div;
      default:    w_rdata = 16'h0000;
    endcase
  end

  assign bus.s_oe   = w_rd;
  assign bus.s_data = w_rdata;

  // Write strobe history, divisor and sticky overflow flag
  always_ff @(posedge clock) begin
    if (reset) begin
      r_prev_nwr <= 1'b1;
      r_div      <= DEFAULT_DIV;
      r_overflow <= 1'b0;
    end else begin
      r_prev_nwr <= bus.memNotWrite;
      if (w_wr && (w_off == OFF_DIV)) r_div <= bus.yBus;
      if (w_push && w_full) begin
        r_overflow <= 1'b1;
      end else if (w_wr && (w_off == OFF_STATUS) && bus.yBus[ST_OVF]) begin
        r_overflow <= 1'b0;
      end
    end
  end

  // TX state register and bit-timing datapath
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= TX_IDLE;
      r_cnt   <= 16'd0;
      r_bit   <= 3'd0;
      r_shift <= 8'd0;
      r_txd   <= 1'b1;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_bit   <= w_bit_n;
      r_shift <= w_shift_n;
      r_txd   <= w_txd_n;
    end
  end

  // TX next-state logic; the counter reloads from r_div at every bit boundary
  // so a divisor change only affects the following bit
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_bit_n   = r_bit;
    w_shift_n = r_shift;
    w_txd_n   = r_txd;
    w_pop     = 1'b0;
    case (r_state)
      TX_IDLE: begin
        if (!w_empty) begin
          w_pop     = 1'b1;
          w_state_n = TX_START;
          w_cnt_n   = r_div;
          w_shift_n = w_fifo_data;
          w_txd_n   = 1'b0;
        end else begin
          w_txd_n   = 1'b1;
        end
      end
      TX_START: begin
        if (r_cnt == 16'd0) begin
          w_state_n = TX_DATA;
          w_cnt_n   = r_div;
          w_bit_n   = 3'd0;
          w_txd_n   = r_shift[0];
        end else begin
          w_cnt_n   = r_cnt - 16'd1;
        end
      end
      TX_DATA: begin
        if (r_cnt == 16'd0) begin
          w_cnt_n = r_div;
          if (r_bit == 3'd7) begin
            w_state_n = TX_STOP;
            w_txd_n   = 1'b1;
          end else begin
            w_bit_n   = r_bit + 3'd1;
            w_shift_n = {1'b0, r_shift[7:1]};
            w_txd_n   = r_shift[1];
          end
        end else begin
          w_cnt_n = r_cnt - 16'd1;
        end
      end
      TX_STOP: begin
        if (r_cnt == 16'd0) begin
          // Back-to-back frames: go straight to the next start bit
          if (!w_empty) begin
            w_pop     = 1'b1;
            w_state_n = TX_START;
            w_cnt_n   = r_div;
            w_shift_n = w_fifo_data;
            w_txd_n   = 1'b0;
          end else begin
            w_state_n = TX_IDLE;
            w_txd_n   = 1'b1;
          end
        end else begin
          w_cnt_n = r_cnt - 16'd1;
        end
      end
      default: begin
        w_state_n = TX_IDLE;
        w_txd_n   = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_uart_tx_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_uart_tx_responder
// Directed bench: a register-access vector table followed by hand-written
// serial frame sequences (single frame, long write pulse, FIFO overflow with
// back-to-back frames, reset mid-frame, optional interrupt).
// ---------------------------------------------------------------------------
module tb_mem_uart_tx_responder;
  import mem_uart_tx_pkg::*;

  localparam logic [15:0] BASE = 16'hFF00;
`ifdef MEM_UART_TX_IRQ_EN
  localparam bit HAS_IRQ = 1'b1;
  logic irq;
`else
  localparam bit HAS_IRQ = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic txd;
  int   total = 0;
  int   bad   = 0;

  mem_uart_tx_responder_if bus ();

  mem_uart_tx_responder #(
    .BASE        (BASE),
    .FIFO_DEPTH  (4),
    .DEFAULT_DIV (16'd433)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus),
    .txd   (txd)
`ifdef MEM_UART_TX_IRQ_EN
    ,
    .irq   (irq)
`endif
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [15:0] d, input int cycles);
    @(negedge clock);
    bus.aBus = a; bus.m_data = d; bus.m_oe = 1'b1; bus.memNotWrite = 1'b0;
    repeat (cycles) @(negedge clock);
    bus.memNotWrite = 1'b1; bus.m_oe = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [15:0] d, output logic drv);
    @(negedge clock);
    bus.aBus = a; bus.memNotRead = 1'b0;
    #1;
    d = bus.yBus; drv = bus.s_oe;
    bus.memNotRead = 1'b1;
  endtask

  // STATUS read at the current time, without consuming a clock
  task automatic peek_status(output logic [15:0] s);
    bus.aBus = BASE + 16'd1; bus.memNotRead = 1'b0;
    #1;
    s = bus.yBus;
    bus.memNotRead = 1'b1;
  endtask

  // Waits up to max_wait negedges for the start bit, then checks every
  // sample of the 8N1 frame (each bit held bclk clocks)
  task automatic check_frame(input logic [7:0] d, input int bclk, input int max_wait, input bit chk_busy);
    logic [9:0]  fr;
    logic [15:0] s;
    int          w;
    bit          found;
    fr = {1'b1, d, 1'b0};
    w = 0; found = 1'b0;
    while (w < max_wait && !found) begin
      @(negedge clock);
      w++;
      if (txd === 1'b0) found = 1'b1;
    end
    check($sformatf("frame %0h start", d), found, 1);
    if (found) begin
      for (int i = 0; i < FRAME_BITS * bclk; i++) begin
        if (i > 0) @(negedge clock);
        check($sformatf("frame %0h sample %0d", d, i), txd, fr[i / bclk]);
        if (chk_busy) begin
          peek_status(s);
          check($sformatf("frame %0h busy %0d", d, i), s[ST_BUSY], 1);
        end
`ifdef MEM_UART_TX_IRQ_EN
        if (i == bclk * 5) check("irq low while busy", irq, 0);
`endif
      end
    end
  endtask

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [15:0] data;
    bit          exp_drv;
    logic [15:0] exp;
  } vec_t;

  vec_t        vecs[14];
  logic [15:0] rd;
  logic        drv;
  logic [7:0]  tx_bytes[6];
  int          ones;

  initial begin
    bus.aBus = 16'h0000; bus.memNotRead = 1'b1; bus.memNotWrite = 1'b1;
    bus.m_data = 16'h0000; bus.m_oe = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check("txd after reset", txd, 1);
`ifdef MEM_UART_TX_IRQ_EN
    check("irq after reset", irq, 0);
`endif

    // Register access table
    vecs[0]  = '{1'b0, BASE + 16'd1, 16'h0000, 1'b1, 16'h0001};
    vecs[1]  = '{1'b0, BASE + 16'd2, 16'h0000, 1'b1, 16'd433};
    vecs[2]  = '{1'b0, BASE + 16'd4, 16'h0000, 1'b0, 16'h0000};
    vecs[3]  = '{1'b0, BASE,         16'h0000, 1'b1, 16'h0000};
    vecs[4]  = '{1'b0, BASE + 16'd3, 16'h0000, 1'b1, 16'h0000};
    vecs[5]  = '{1'b0, BASE - 16'd1, 16'h0000, 1'b0, 16'h0000};
    vecs[6]  = '{1'b1, BASE + 16'd2, 16'h1234, 1'b0, 16'h0000};
    vecs[7]  = '{1'b0, BASE + 16'd2, 16'h0000, 1'b1, 16'h1234};
    vecs[8]  = '{1'b1, BASE + 16'd3, 16'hFFFF, 1'b0, 16'h0000};
    vecs[9]  = '{1'b0, BASE + 16'd3, 16'h0000, 1'b1, 16'h0000};
    vecs[10] = '{1'b1, BASE + 16'd1, 16'h0100, 1'b0, 16'h0000};
    vecs[11] = '{1'b0, BASE + 16'd1, 16'h0000, 1'b1, HAS_IRQ ? 16'h0101 : 16'h0001};
    vecs[12] = '{1'b1, BASE + 16'd1, 16'h0000, 1'b0, 16'h0000};
    vecs[13] = '{1'b0, BASE + 16'd1, 16'h0000, 1'b1, 16'h0001};
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].wr) begin
        bus_write(vecs[i].addr, vecs[i].data, 1);
      end else begin
        bus_read(vecs[i].addr, rd, drv);
        check($sformatf("vec %0d drive", i), drv, vecs[i].exp_drv);
        if (vecs[i].exp_drv) check($sformatf("vec %0d data", i), rd, vecs[i].exp);
      end
    end

    // Both strobes low: write DIV=3, yBus must not be driven by the slave
    @(negedge clock);
    bus.aBus = BASE + 16'd2; bus.m_data = 16'd3; bus.m_oe = 1'b1;
    bus.memNotWrite = 1'b0; bus.memNotRead = 1'b0;
    #1;
    check("both strobes no drive", bus.s_oe, 0);
    @(negedge clock);
    bus.memNotWrite = 1'b1; bus.memNotRead = 1'b1; bus.m_oe = 1'b0;
    bus_read(BASE + 16'd2, rd, drv);
    check("div readback 3", rd, 16'd3);

    // Single frame 0xA5 with exact start latency and busy tracking
    bus_write(BASE, 16'h00A5, 1);
    peek_status(rd);
    check("status after push", rd, 16'h0010);
    check_frame(8'hA5, 4, 1, 1'b1);
    @(negedge clock);
    check("txd idle after frame", txd, 1);
    peek_status(rd);
    check("status idle after frame", rd, 16'h0001);

    // Long write pulse produces exactly one frame
    fork
      bus_write(BASE, 16'h0055, 5);
      check_frame(8'h55, 4, 3, 1'b0);
    join
    ones = 0;
    repeat (48) begin
      @(negedge clock);
      if (txd === 1'b1) ones++;
    end
    check("no second frame", ones, 48);
    bus_read(BASE + 16'd1, rd, drv);
    check("status after long pulse", rd, 16'h0001);

    // Six pushes into a 4-deep FIFO: five gap-free frames, one dropped
    tx_bytes[0] = 8'h11; tx_bytes[1] = 8'h22; tx_bytes[2] = 8'h33;
    tx_bytes[3] = 8'h44; tx_bytes[4] = 8'h55; tx_bytes[5] = 8'h66;
    fork
      begin
        for (int k = 0; k < 6; k++) bus_write(BASE, {8'h00, tx_bytes[k]}, 1);
      end
      begin
        check_frame(tx_bytes[0], 4, 4, 1'b0);
        for (int k = 1; k < 5; k++) check_frame(tx_bytes[k], 4, 1, 1'b0);
      end
    join
    @(negedge clock);
    check("txd idle after burst", txd, 1);
    bus_read(BASE + 16'd1, rd, drv);
    check("status overflow set", rd, 16'h0009);
    bus_write(BASE + 16'd1, 16'h0008, 1);
    bus_read(BASE + 16'd1, rd, drv);
    check("status overflow cleared", rd, 16'h0001);

    // Reset during data bit 4 of 0xA5 with a second byte still queued
    bus_write(BASE, 16'h00A5, 1);
    bus_write(BASE, 16'h003C, 1);
    repeat (20) @(negedge clock);
    check("txd in data bit 4", txd, 0);
    reset = 1'b1;
    @(negedge clock);
    check("txd after mid-frame reset", txd, 1);
    reset = 1'b0;
    bus_read(BASE + 16'd1, rd, drv);
    check("status after mid-frame reset", rd, 16'h0001);
    bus_read(BASE + 16'd2, rd, drv);
    check("div after mid-frame reset", rd, 16'd433);

`ifdef MEM_UART_TX_IRQ_EN
    bus_write(BASE + 16'd1, 16'h0100, 1);
    repeat (2) @(negedge clock);
    check("irq idle enabled", irq, 1);
    bus_write(BASE + 16'd2, 16'd3, 1);
    bus_write(BASE, 16'h005A, 1);
    check_frame(8'h5A, 4, 1, 1'b0);
    @(negedge clock);
    check("irq just after stop", irq, 0);
    @(negedge clock);
    check("irq one clock after stop", irq, 1);
    bus_write(BASE + 16'd1, 16'h0000, 1);
    @(negedge clock);
    check("irq after disable", irq, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
